// File: rtl/display_pkg.sv
// Shared display types, raster geometry and sprite-buffer FSM states.
// Also holds the visible-area clamp helpers used when the
// SPRITE_CLAMP_EN build macro is defined.
package display_pkg;

    typedef logic [10:0] row_t;
    typedef logic [11:0] col_t;

    localparam int H_TOTAL_C       = 2160;
    localparam int V_TOTAL_C       = 1250;
    localparam int H_VISIBLE_C     = 1600;
    localparam int V_VISIBLE_C     = 1200;
    localparam int SPRITE_RADIUS_C = 31;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } buf_state_t;

    // Pull a row back to the last visible line (unsigned compare).
    function automatic row_t clamp_row(input row_t r);
        return (r > row_t'(V_VISIBLE_C - 1)) ? row_t'(V_VISIBLE_C - 1) : r;
    endfunction

    // Pull a column back to the last visible pixel (unsigned compare).
    function automatic col_t clamp_col(input col_t c);
        return (c > col_t'(H_VISIBLE_C - 1)) ? col_t'(H_VISIBLE_C - 1) : c;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter shared in spirit with VGA_driver: same wrap
// rules and reset alignment. Flags the last pixel of the frame and
// emits a registered pulse while the counter reads (0,0).
module raster_counter
    import display_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_C,
    parameter int V_TOTAL = V_TOTAL_C
) (
    input  logic clock_162,
    input  logic rst,
    output logic end_of_frame,
    output logic frame_tick
);

    row_t row;
    col_t col;

    assign end_of_frame = (row == row_t'(V_TOTAL - 1)) && (col == col_t'(H_TOTAL - 1));

    // Column counts every pixel; row advances on column wrap.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (col == col_t'(H_TOTAL - 1)) begin
            col <= '0;
            row <= (row == row_t'(V_TOTAL - 1)) ? '0 : row + 1'b1;
        end else begin
            col <= col + 1'b1;
        end
    end

    // The cycle after the last pixel is exactly raster (0,0).
    always_ff @(posedge clock_162) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= end_of_frame;
    end

endmodule

// File: rtl/sprite_position_buffer.sv
// Double-buffered sprite positions feeding VGA_driver. Updates land in a
// shadow bank; a commit copies shadow to active only on the last pixel of
// a frame, so a displayed frame never mixes old and new positions.
// Build macro SPRITE_CLAMP_EN: clamp updates to the visible area before
// they are stored.
module sprite_position_buffer
    import display_pkg::*;
#(
    parameter int SPRITES   = 4,
    parameter int H_TOTAL   = H_TOTAL_C,
    parameter int V_TOTAL   = V_TOTAL_C,
    parameter int RESET_ROW = 600,
    parameter int RESET_COL = 800,
    localparam int IDX_W    = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
    input  logic                     clock_162,
    input  logic                     rst,
    input  logic                     upd_valid,
    input  logic [IDX_W-1:0]         upd_index,
    input  logic [10:0]              upd_row,
    input  logic [11:0]              upd_col,
    input  logic                     commit_valid,
    output logic                     upd_ready,
    output logic [SPRITES-1:0][10:0] sprite_row,
    output logic [SPRITES-1:0][11:0] sprite_col,
    output logic                     frame_tick,
    output logic                     swap_done
);

    buf_state_t state;
    logic       end_of_frame;
    logic       idx_ok;
    row_t       wr_row;
    col_t       wr_col;
    row_t       shadow_row [SPRITES];
    col_t       shadow_col [SPRITES];

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .clock_162    (clock_162),
        .rst          (rst),
        .end_of_frame (end_of_frame),
        .frame_tick   (frame_tick)
    );

`ifdef SPRITE_CLAMP_EN
    assign wr_row = clamp_row(upd_row);
    assign wr_col = clamp_col(upd_col);
`else
    assign wr_row = upd_row;
    assign wr_col = upd_col;
`endif

    // Out-of-range indices still complete the handshake but write nothing.
    assign idx_ok    = (32'(upd_index) < SPRITES);
    assign upd_ready = (state == IDLE);

    // Shadow bank: written only while idle, so a pending commit is frozen.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            for (int i = 0; i < SPRITES; i++) begin
                shadow_row[i] <= row_t'(RESET_ROW);
                shadow_col[i] <= col_t'(RESET_COL);
            end
        end else if (state == IDLE && upd_valid && idx_ok) begin
            shadow_row[upd_index] <= wr_row;
            shadow_col[upd_index] <= wr_col;
        end
    end

    // Commit FSM and active bank; a commit taken on the last pixel waits a
    // whole frame because the swap only fires from PENDING.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            state     <= IDLE;
            swap_done <= 1'b0;
            for (int i = 0; i < SPRITES; i++) begin
                sprite_row[i] <= row_t'(RESET_ROW);
                sprite_col[i] <= col_t'(RESET_COL);
            end
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_valid) state <= PENDING;
                end
                PENDING: begin
                    if (end_of_frame) begin
                        for (int i = 0; i < SPRITES; i++) begin
                            sprite_row[i] <= shadow_row[i];
                            sprite_col[i] <= shadow_col[i];
                        end
                        state     <= IDLE;
                        swap_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
